uart_tx_piso: RTL
=================

// Module: uart_tx_piso
// PURPOSE
//  Transmit half of the UART link. Accepts one data byte via a valid/ready handshake.
//  Builds an 11-bit frame {stop=1, parity, data[7:0], start=0}.
//  Shifts the frame out LSB-first on data_tx, holding each bit OVERSAMPLE baud_clk cycles.
//  Feeds the serial receiver, whose 11-bit parallel capture equals this frame bit-for-bit.
// PARAMETERS
//  DATA_W      8   payload width; frame width FRAME_BITS = DATA_W+3 (fixed at 11 for the link)
//  OVERSAMPLE  16  baud_clk cycles per serial bit (must match receiver sampling)
// PORTS
//  baud_clk     in   1       oversampled bit clock, rising-edge
//  rst          in   1       asynchronous reset, active-high
//  tx_valid     in   1       tx_data holds a byte to send
//  tx_data      in   DATA_W  payload byte, sampled only on the accept edge
//  parity_odd   in   1       0 = even parity, 1 = odd parity; sampled on the accept edge
//  tx_ready     out  1       block in IDLE and able to accept
//  data_tx      out  1       serial line, idle high; registered (glitch-free)
//  active_flag  out  1       high while a frame is on the line (SEND state)
//  tx_done      out  1       one-cycle pulse after the stop bit completes
// BEHAVIOUR
//  Reset (async, while rst=1):
//   - state=IDLE; data_tx=1; tx_ready=1; active_flag=0; tx_done=0; counters=0.
//   - Mid-frame reset: frame abandoned, line forced high at once, no tx_done.
//  States: IDLE -> SEND -> DONE -> IDLE.
//   IDLE: tx_ready=1. On an edge with tx_valid=1:
//    - latch shreg = {1'b1, par, tx_data, 1'b0}
//    - par = ^tx_data ^ parity_odd
//    - os_cnt=0, bit_cnt=0; data_tx<=0 (start bit); go to SEND.
//   SEND: tx_ready=0, active_flag=1. Each edge:
//    - os_cnt < OVERSAMPLE-1: os_cnt++; data_tx held.
//    - os_cnt == OVERSAMPLE-1 and bit_cnt < FRAME_BITS-1:
//      os_cnt=0, bit_cnt++, shreg>>=1, data_tx <= next frame bit.
//    - os_cnt == OVERSAMPLE-1 and bit_cnt == FRAME_BITS-1:
//      data_tx<=1, go to DONE.
//   DONE: exactly one cycle. tx_done=1, tx_ready=0, data_tx=1; then IDLE.
//  Timing, accept edge = k:
//   - data_tx low in cycles k..k+15; bit n occupies cycles k+16n .. k+16n+15.
//   - Frame occupies 176 cycles. DONE entered at edge k+176; IDLE at k+177.
//   - Earliest next accept is edge k+178; line stays high >=2 cycles between frames.
//  Handshake:
//   - tx_valid while tx_ready=0 is ignored and not queued; upstream holds valid.
//   - tx_data and parity_odd changes after the accept edge do not affect the frame.
//  Width rules: os_cnt is clog2(OVERSAMPLE) bits; bit_cnt is 4 bits; no wrap in range.
//  Unused state encodings recover to IDLE with data_tx=1.
// TESTING
//  1 Reset: assert rst mid-run -> data_tx=1, tx_ready=1, active_flag=0, tx_done=0
//    while rst is high.
//  2 Send 0xA5, even parity:
//    - line bits 0,1,0,1,0,0,1,0,1,0,1, each 16 cycles wide.
//    - tx_done pulses once, at cycle k+176.
//  3 Send 0xFF, odd parity -> parity bit (bit 9) = 1.
//    Send 0x00, even parity -> parity bit = 0.
//  4 Back-to-back, tx_valid held high with 0x3C then 0xC3:
//    - second accept exactly at k+178; no glitch or low between frames.
//    - tx_data change during the first frame does not alter it.
//  5 Reset during bit 4 of a frame:
//    - data_tx=1 immediately, no tx_done.
//    - after release, 0x5A is sent correctly.
//  6 Loopback into the receiver (rst inverted to its rst_n), random 200 bytes
//    with random parity:
//    - receiver data_parll == {1,par,byte,0} for every frame.

Source files
------------

// File: rtl/uart_tx_piso.sv
// UART transmit shifter: accepts a byte on a valid/ready handshake and sends
// {stop, parity, data, start} LSB-first, each bit held OVERSAMPLE baud_clk cycles.
module uart_tx_piso #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic              baud_clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_odd,
    output logic              tx_ready,
    output logic              data_tx,
    output logic              active_flag,
    output logic              tx_done
);

    localparam int FRAME_BITS = DATA_W + 3;
    localparam int OS_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      BIT_LAST = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [OS_W-1:0]       os_cnt, os_next;
    logic [3:0]            bit_cnt, bit_next;
    logic [FRAME_BITS-2:0] shreg, shreg_next;
    logic                  line_next;

    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            data_tx <= 1'b1;
        end else begin
            state   <= state_next;
            os_cnt  <= os_next;
            bit_cnt <= bit_next;
            data_tx <= line_next;
        end
    end

    // Payload register carries no reset: it is always reloaded on the accept edge.
    always_ff @(posedge baud_clk) begin
        shreg <= shreg_next;
    end

    // The start bit goes straight to the line, so shreg holds only the bits after it.
    always_comb begin
        state_next = state;
        os_next    = os_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        line_next  = data_tx;
        case (state)
            IDLE: begin
                line_next = 1'b1;
                if (tx_valid) begin
                    shreg_next = {1'b1, parity_bit(tx_data, parity_odd), tx_data};
                    os_next    = '0;
                    bit_next   = '0;
                    line_next  = 1'b0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (os_cnt < OS_LAST) begin
                    os_next = os_cnt + 1'b1;
                end else if (bit_cnt < BIT_LAST) begin
                    os_next    = '0;
                    bit_next   = bit_cnt + 4'd1;
                    line_next  = shreg[0];
                    shreg_next = shreg >> 1;
                end else begin
                    line_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                line_next  = 1'b1;
                os_next    = '0;
                bit_next   = '0;
                state_next = IDLE;
            end
            default: begin
                line_next  = 1'b1;
                os_next    = '0;
                bit_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign tx_ready    = (state == IDLE);
    assign active_flag = (state == SEND);
    assign tx_done     = (state == DONE);

endmodule
